// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
//   Instruction-memory bus between the fetch unit and instruction memory.
//   Request channel : imem_req_valid / imem_req_ready / imem_req_addr
//   Response channel: imem_resp_valid / imem_resp_data
//     (in request order, variable latency, no backpressure)
//
//   master : fetch unit (drives requests, receives responses)
//   slave  : instruction memory
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage feeding the IF/ID register. Generates sequential
//   word fetches, buffers returned instructions with their PCs in a small
//   FIFO and presents the FIFO head downstream. Handles downstream stall and
//   branch/jump redirects, discarding wrong-path responses still in flight.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  buffer entries (power of 2, >= 2); also the request credit
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   stall             downstream not accepting; hold current output
//   redirect_valid    single-cycle taken branch/jump pulse
//   redirect_pc       redirect target, bits [1:0] ignored
//   imem              instruction-memory bus (master side)
//   instr_out/pc_out  FIFO head (NOP / 0 when empty)
//   instr_valid       instr_out/pc_out valid
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           instr_out,
    output logic [31:0]           pc_out,
    output logic                  instr_valid
);

    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    // Credit limit, one bit wider than the counters so the sum never wraps.
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("if_fetch_unit: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_fetch_pc;      // next address to request
    logic [31:0]   r_resp_pc;       // PC belonging to the next kept response
    logic [CW-1:0] r_outstanding;   // requests accepted, response not yet seen
    logic [CW-1:0] r_drop_cnt;      // in-flight responses that are wrong-path
    logic [CW-1:0] r_count;         // FIFO occupancy
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_instr_q [FIFO_DEPTH];
    logic [31:0]   r_pc_q    [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [CW:0] w_credit_used;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_resp;
    logic        w_dropping;
    logic        w_push;
    logic        w_not_empty;
    logic        w_instr_valid;
    logic        w_pop;
    logic [31:0] w_redirect_target;
    logic        w_unused_pc_lsbs;

    // Every in-flight request owns a FIFO slot, so responses never need
    // backpressure. A pop in the current cycle does not free a credit yet.
    assign w_credit_used     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid       = !reset && !redirect_valid && (w_credit_used < CREDIT_LIMIT);
    assign w_req_fire        = w_req_valid && imem.imem_req_ready;

    assign w_resp            = imem.imem_resp_valid;
    assign w_dropping        = (r_drop_cnt != '0);
    // A response landing in the redirect cycle is wrong-path by definition.
    assign w_push            = w_resp && !w_dropping && !redirect_valid;

    assign w_not_empty       = (r_count != '0);
    assign w_instr_valid     = w_not_empty && !redirect_valid;
    assign w_pop             = w_instr_valid && !stall;

    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs  = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;

    assign instr_valid = w_instr_valid;
    assign instr_out   = w_not_empty ? r_instr_q[r_rd_ptr] : NOP;
    assign pc_out      = w_not_empty ? r_pc_q[r_rd_ptr]    : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            // No request fires during a redirect, so this is valid in all cases.
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp);

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
                r_resp_pc  <= w_redirect_target;
                // r_outstanding already includes anything still owed to an
                // earlier redirect, so after this edge every response still
                // in flight is wrong-path. Recomputing from it (rather than
                // accumulating) keeps back-to-back redirects exact.
                r_drop_cnt <= r_outstanding - CW'(w_resp);
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;

                if (w_resp && w_dropping)
                    r_drop_cnt <= r_drop_cnt - CW'(1);

                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                end

                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);

                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents are don't-care while empty, so no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= imem.imem_resp_data;
            r_pc_q[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. The reference model tracks each
//   in-flight request by its own address plus a keep/discard flag and the
//   instruction buffer as a queue of {instr, pc}; it is compared against the
//   DUT every negative clock edge. Directed phases pin the model with
//   literal expectations, then a randomized phase exercises stall, redirect,
//   memory backpressure and variable latency.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] addr; bit keep; } flight_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    flight_t     m_fl[$];     // requests in flight, oldest first
    ent_t        m_buf[$];    // buffered instructions, head first
    logic [31:0] m_fetch_pc;

    logic [31:0] log_req[$];  // accepted request addresses
    int          log_req_cyc[$];
    ent_t        log_out[$];  // instructions accepted downstream
    int          log_out_cyc[$];
    int          ncyc = 0;

    mem_t        mq[$];       // memory: pending responses
    int          ecnt = 0;
    int          last_due = 0;
    int          lat_lo = 1, lat_hi = 1;

    bit          rnd = 0;
    int          stall_pct = 0, redir_pct = 0, ready_pct = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] req_at(input int i);
        return (i < log_req.size()) ? log_req[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] outpc_at(input int i);
        return (i < log_out.size()) ? log_out[i].pc : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] outins_at(input int i);
        return (i < log_out.size()) ? log_out[i].instr : 32'hxxxx_xxxx;
    endfunction

    // ---------------- model: compare then advance one edge ----------------
    task automatic model_cycle();
        bit      exp_rv, exp_iv, do_pop, fire;
        flight_t h;
        ncyc++;
        if (reset) begin
            chk("rst_req_valid",   imem.imem_req_valid, 32'd0);
            chk("rst_instr_valid", instr_valid, 32'd0);
            chk("rst_instr_out",   instr_out, NOP);
            chk("rst_pc_out",      pc_out, 32'd0);
            m_fl.delete();
            m_buf.delete();
            m_fetch_pc = 32'h0;
            return;
        end
        exp_rv = !redirect_valid && (m_fl.size() + m_buf.size() < DEPTH);
        exp_iv = (m_buf.size() > 0) && !redirect_valid;
        chk("req_valid", imem.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem.imem_req_addr, m_fetch_pc);
        chk("instr_valid", instr_valid, exp_iv);
        if (m_buf.size() > 0) begin
            chk("instr_out", instr_out, m_buf[0].instr);
            chk("pc_out", pc_out, m_buf[0].pc);
        end else begin
            chk("instr_out_empty", instr_out, NOP);
            chk("pc_out_empty", pc_out, 32'd0);
        end

        // next state at the coming edge
        do_pop = exp_iv && !stall;
        fire   = exp_rv && imem.imem_req_ready;
        if (redirect_valid) begin
            m_buf.delete();
        end else if (do_pop) begin
            log_out.push_back(m_buf[0]);
            log_out_cyc.push_back(ncyc);
            void'(m_buf.pop_front());
        end
        if (imem.imem_resp_valid && m_fl.size() > 0) begin
            h = m_fl.pop_front();
            if (h.keep && !redirect_valid)
                m_buf.push_back('{imem.imem_resp_data, h.addr});
        end
        if (redirect_valid) begin
            foreach (m_fl[i]) m_fl[i].keep = 1'b0;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end
        if (fire) begin
            m_fl.push_back('{m_fetch_pc, 1'b1});
            log_req.push_back(m_fetch_pc);
            log_req_cyc.push_back(ncyc);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
    endtask

    // ---------------- one clock: check at negedge, drive after posedge ----------------
    task automatic step();
        bit          acc;
        logic [31:0] acc_addr;
        int          lat, due;
        @(negedge clk);
        model_cycle();
        acc      = !reset && imem.imem_req_valid && imem.imem_req_ready;
        acc_addr = imem.imem_req_addr;
        @(posedge clk);
        #1;
        ecnt++;
        if (reset) begin
            mq.delete();
            last_due = ecnt;
            imem.imem_resp_valid = 1'b0;
            imem.imem_resp_data  = 32'h0;
        end else begin
            if (acc) begin
                lat = $urandom_range(lat_hi, lat_lo);
                due = ecnt + lat - 1;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{acc_addr, due});
            end
            if (mq.size() > 0 && mq[0].due <= ecnt) begin
                imem.imem_resp_valid = 1'b1;
                imem.imem_resp_data  = mq[0].addr ^ XORK;
                void'(mq.pop_front());
            end else begin
                imem.imem_resp_valid = 1'b0;
                imem.imem_resp_data  = $urandom;
            end
        end
        if (rnd) begin
            stall               = ($urandom_range(99) < stall_pct);
            redirect_valid      = ($urandom_range(99) < redir_pct);
            imem.imem_req_ready = ($urandom_range(99) < ready_pct);
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                        redirect_pc = $urandom;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          r0, o0;
        logic [31:0] held;
        reset               = 1'b1;
        stall               = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        imem.imem_req_ready = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data = 32'h0;

        step(); step();
        reset = 1'b0;

        // 1: streaming from reset with 1-cycle memory
        r0 = log_req.size(); o0 = log_out.size();
        repeat (10) step();
        chk("t1_req0", req_at(r0),     32'h0);
        chk("t1_req1", req_at(r0 + 1), 32'h4);
        chk("t1_req2", req_at(r0 + 2), 32'h8);
        chk("t1_pc0",  outpc_at(o0),     32'h0);
        chk("t1_pc1",  outpc_at(o0 + 1), 32'h4);
        chk("t1_pc2",  outpc_at(o0 + 2), 32'h8);
        chk("t1_ins0", outins_at(o0),     32'hA5A5_0000);
        chk("t1_ins1", outins_at(o0 + 1), 32'hA5A5_0004);
        if (log_out_cyc.size() > o0 && log_req_cyc.size() > r0)
            chk("t1_latency", log_out_cyc[o0] - log_req_cyc[r0], 32'd2);
        else
            chk("t1_latency", 32'hxxxx_xxxx, 32'd2);

        // 2: stall for 5 cycles fills the buffer and holds the output
        stall = 1'b1;
        step(); step();
        #1 held = pc_out;
        step(); step(); step();
        #1;
        chk("t2_held_pc",    pc_out, held);
        chk("t2_valid",      instr_valid, 32'd1);
        chk("t2_req_off",    imem.imem_req_valid, 32'd0);
        stall = 1'b0;
        o0 = log_out.size();
        repeat (8) step();
        chk("t2_resume0", outpc_at(o0),     held);
        chk("t2_resume1", outpc_at(o0 + 1), held + 32'd4);
        chk("t2_resume2", outpc_at(o0 + 2), held + 32'd8);

        // 3: 3-cycle memory, redirect with two requests in flight
        imem.imem_req_ready = 1'b0;
        repeat (6) step();
        lat_lo = 3; lat_hi = 3;
        imem.imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("t3_no_req_in_redirect", imem.imem_req_valid, 32'd0);
        r0 = log_req.size(); o0 = log_out.size();
        step();
        redirect_valid = 1'b0;
        repeat (14) step();
        chk("t3_prev_req1", (r0 >= 2) ? log_req[r0 - 1] : 32'hxxxx_xxxx, 32'h14);
        chk("t3_next_req",  req_at(r0), 32'h100);
        chk("t3_first_pc",  outpc_at(o0), 32'h100);
        chk("t3_first_ins", outins_at(o0), 32'hA5A5_0100);
        chk("t3_second_pc", outpc_at(o0 + 1), 32'h104);

        // 4: async reset, then memory not ready for 4 cycles
        lat_lo = 1; lat_hi = 1;
        #2 reset = 1'b1;
        #1;
        chk("t4_async_req_valid",   imem.imem_req_valid, 32'd0);
        chk("t4_async_instr_valid", instr_valid, 32'd0);
        chk("t4_async_instr_out",   instr_out, NOP);
        chk("t4_async_pc_out",      pc_out, 32'd0);
        step(); step();
        reset = 1'b0;
        imem.imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("t4_hold_valid", imem.imem_req_valid, 32'd1);
            chk("t4_hold_addr",  imem.imem_req_addr, 32'h0);
        end
        imem.imem_req_ready = 1'b1;
        step();
        #1;
        chk("t4_advance_addr", imem.imem_req_addr, 32'h4);

        // 5: unaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        r0 = log_req.size(); o0 = log_out.size();
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t5_addr", imem.imem_req_addr, 32'h100);
        repeat (10) step();
        chk("t5_req", req_at(r0), 32'h100);
        chk("t5_pc",  outpc_at(o0), 32'h100);

        // 6: address wrap at 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        r0 = log_req.size(); o0 = log_out.size();
        step();
        redirect_valid = 1'b0;
        repeat (10) step();
        chk("t6_req0", req_at(r0),     32'hFFFF_FFFC);
        chk("t6_req1", req_at(r0 + 1), 32'h0);
        chk("t6_pc0",  outpc_at(o0),     32'hFFFF_FFFC);
        chk("t6_pc1",  outpc_at(o0 + 1), 32'h0);
        chk("t6_ins1", outins_at(o0 + 1), 32'hA5A5_0000);

        // randomized phase
        rnd = 1;
        for (int phase = 0; phase < 6; phase++) begin
            stall_pct = $urandom_range(60);
            redir_pct = $urandom_range(8);
            ready_pct = 40 + $urandom_range(60);
            lat_lo    = 1;
            lat_hi    = 1 + $urandom_range(3);
            repeat (500) step();
            if (phase == 3) begin
                #3 reset = 1'b1;
                #1;
                chk("rnd_async_req_valid",   imem.imem_req_valid, 32'd0);
                chk("rnd_async_instr_valid", instr_valid, 32'd0);
                chk("rnd_async_instr_out",   instr_out, NOP);
                chk("rnd_async_pc_out",      pc_out, 32'd0);
                step(); step();
                reset = 1'b0;
            end
        end
        rnd = 0;
        redirect_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
